sincos_req_arbiter: RTL and testbench



---
 rtl/sincos_req_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_sincos_req_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sincos_req_arbiter.sv
// ---------------------------------------------------------------------------
// sincos_req_arbiter
//
// Shares one sincos_TOP datapath among N_REQ requesters. A round-robin
// arbiter issues at most one Theta per cycle, bounded by a credit of
// MAX_OUTSTANDING in-flight operations. Each issue pushes the requester ID
// into an in-order FIFO. The core's independent sin and cos strobes are
// joined, and each completed pair goes back to the requester at the FIFO
// head.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   req_valid[N_REQ]                per-requester Theta valid
//   req_theta[N_REQ*DATA_WIDTH]     requester i Theta at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready[N_REQ]                one-hot grant (combinational)
//   sc_theta_valid, sc_theta        issue port to sincos_TOP
//   sc_sin_valid, sc_sin            sin result from sincos_TOP
//   sc_cos_valid, sc_cos            cos result from sincos_TOP
//   rsp_valid[N_REQ]                one-hot one-cycle result pulse
//   rsp_sin, rsp_cos                shared result bus, held between pulses
//   busy                            any operation outstanding
//   err_orphan                      result with no owner, or join hold overflow
// ---------------------------------------------------------------------------
module sincos_req_arbiter #(
    parameter int N_REQ           = 4,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_theta,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        sc_theta_valid,
    output logic [DATA_WIDTH-1:0]       sc_theta,
    input  logic                        sc_sin_valid,
    input  logic [DATA_WIDTH-1:0]       sc_sin,
    input  logic                        sc_cos_valid,
    input  logic [DATA_WIDTH-1:0]       sc_cos,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_sin,
    output logic [DATA_WIDTH-1:0]       rsp_cos,
    output logic                        busy,
    output logic                        err_orphan
);

    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int DEPTH = 1 << PW;
    localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    // Control state
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic                  sin_hold_q, sin_hold_d;
    logic                  cos_hold_q, cos_hold_d;
    logic                  sc_theta_valid_q;
    logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] sc_theta_q, rsp_sin_q, rsp_cos_q;

    // Data-only state (no reset needed)
    logic [IDW-1:0]        fifo_q [DEPTH];
    logic [DATA_WIDTH-1:0] sin_val_q, sin_val_d;
    logic [DATA_WIDTH-1:0] cos_val_q, cos_val_d;

    // Combinational
    logic                  credit, found, push, pop, fifo_empty;
    logic [IDW-1:0]        gnt_idx;
    logic [N_REQ-1:0]      gnt_oh;
    logic                  sin_have, cos_have, pair_done, sin_ovf, cos_ovf;
    logic [DATA_WIDTH-1:0] pair_sin, pair_cos;
    logic [IDW-1:0]        head_id;

    // Credit uses the pre-edge count, so a pop in the same cycle cannot
    // free a slot for a new grant until the following cycle.
    assign credit     = (count_q < MAX_CNT);
    assign fifo_empty = (count_q == '0);
    assign head_id    = fifo_q[rd_ptr_q];

    // Round-robin search starting at ptr_q, wrapping modulo N_REQ.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        if (credit && !rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && req_valid[(int'(ptr_q) + k) % N_REQ]) begin
                    found   = 1'b1;
                    gnt_idx = IDW'((int'(ptr_q) + k) % N_REQ);
                end
            end
        end
        if (found) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    assign push  = found;
    assign ptr_d = found ? IDW'((int'(gnt_idx) + 1) % N_REQ) : ptr_q;

    // Join: a pair completes when each half is either held or strobing now.
    assign sin_have  = sin_hold_q | sc_sin_valid;
    assign cos_have  = cos_hold_q | sc_cos_valid;
    assign pair_done = sin_have & cos_have;
    assign pair_sin  = sin_hold_q ? sin_val_q : sc_sin;
    assign pair_cos  = cos_hold_q ? cos_val_q : sc_cos;
    assign pop       = pair_done & !fifo_empty;

    always_comb begin
        sin_hold_d = sin_hold_q;
        sin_val_d  = sin_val_q;
        sin_ovf    = 1'b0;
        if (pair_done) begin
            // The held value is consumed; a simultaneous new strobe refills it.
            sin_hold_d = sin_hold_q & sc_sin_valid;
            if (sin_hold_q && sc_sin_valid) begin
                sin_val_d = sc_sin;
            end
        end else if (sc_sin_valid) begin
            if (sin_hold_q) begin
                sin_ovf = 1'b1;
            end else begin
                sin_hold_d = 1'b1;
                sin_val_d  = sc_sin;
            end
        end
    end

    always_comb begin
        cos_hold_d = cos_hold_q;
        cos_val_d  = cos_val_q;
        cos_ovf    = 1'b0;
        if (pair_done) begin
            cos_hold_d = cos_hold_q & sc_cos_valid;
            if (cos_hold_q && sc_cos_valid) begin
                cos_val_d = sc_cos;
            end
        end else if (sc_cos_valid) begin
            if (cos_hold_q) begin
                cos_ovf = 1'b1;
            end else begin
                cos_hold_d = 1'b1;
                cos_val_d  = sc_cos;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        rsp_valid_d = '0;
        if (pop) begin
            rsp_valid_d[head_id] = 1'b1;
        end
        err_d = sin_ovf | cos_ovf | (pair_done & fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q            <= '0;
            count_q          <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            sin_hold_q       <= 1'b0;
            cos_hold_q       <= 1'b0;
            sc_theta_valid_q <= 1'b0;
            sc_theta_q       <= '0;
            rsp_valid_q      <= '0;
            rsp_sin_q        <= '0;
            rsp_cos_q        <= '0;
            err_q            <= 1'b0;
        end else begin
            ptr_q            <= ptr_d;
            count_q          <= count_d;
            sin_hold_q       <= sin_hold_d;
            cos_hold_q       <= cos_hold_d;
            sc_theta_valid_q <= push;
            rsp_valid_q      <= rsp_valid_d;
            err_q            <= err_d;
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + PW'(1);
                sc_theta_q <= req_theta[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + PW'(1);
                rsp_sin_q <= pair_sin;
                rsp_cos_q <= pair_cos;
            end
        end
    end

    always_ff @(posedge clk) begin
        sin_val_q <= sin_val_d;
        cos_val_q <= cos_val_d;
        if (push && !rst) begin
            fifo_q[wr_ptr_q] <= gnt_idx;
        end
    end

    assign req_ready      = gnt_oh;
    assign sc_theta_valid = sc_theta_valid_q;
    assign sc_theta       = sc_theta_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_sin        = rsp_sin_q;
    assign rsp_cos        = rsp_cos_q;
    assign busy           = (count_q != '0);
    assign err_orphan     = err_q;

endmodule

// File: tb/tb_sincos_req_arbiter.sv
module tb_sincos_req_arbiter;
    localparam int N    = 4;
    localparam int DW   = 64;
    localparam int MAXO = 8;
    localparam int RING = 128;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_theta;
    logic [N-1:0]    req_ready;
    logic            sc_theta_valid;
    logic [DW-1:0]   sc_theta;
    logic            sc_sin_valid, sc_cos_valid;
    logic [DW-1:0]   sc_sin, sc_cos;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_sin, rsp_cos;
    logic            busy, err_orphan;

    always #5 clk = ~clk;

    sincos_req_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_theta(req_theta), .req_ready(req_ready),
        .sc_theta_valid(sc_theta_valid), .sc_theta(sc_theta),
        .sc_sin_valid(sc_sin_valid), .sc_sin(sc_sin),
        .sc_cos_valid(sc_cos_valid), .sc_cos(sc_cos),
        .rsp_valid(rsp_valid), .rsp_sin(rsp_sin), .rsp_cos(rsp_cos),
        .busy(busy), .err_orphan(err_orphan)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stand-in core arithmetic: any fixed function of Theta will do.
    function automatic logic [63:0] core_sin(input logic [63:0] th);
        return th ^ 64'h5A5A_C3C3_0F0F_9696;
    endfunction
    function automatic logic [63:0] core_cos(input logic [63:0] th);
        return {th[31:0], th[63:32]} + 64'd17;
    endfunction

    // Core model: scheduled result strobes indexed by cycle
    logic          rs_v [RING];
    logic          rc_v [RING];
    logic [63:0]   rs_d [RING];
    logic [63:0]   rc_d [RING];

    // Reference model state
    int            ptr_m = 0;
    int            id_q[$];
    logic [63:0]   sinp[$];
    logic [63:0]   cosp[$];
    logic [N-1:0]  e_rsp = '0;
    logic [63:0]   e_sin = '0, e_cos = '0, e_sct = '0;
    logic          e_err = 1'b0, e_scv = 1'b0;

    // Stimulus controls
    int            lat = 20, skew = 0, vpct = 0, budget = -1;
    logic          rst_drv = 1'b1;
    logic          use_fix = 1'b0, fix_th = 1'b0, extra_sin = 1'b0;
    logic [N-1:0]  vfix = '0;
    logic [63:0]   th_fix = '0;
    int            err_win = 0, rsp_win = 0;

    task automatic step();
        logic [N-1:0] v;
        logic         ss, cs;
        logic [63:0]  sv, cv, ps, pc;
        int           g, slot;
        // registered outputs against expectations from the previous edge
        chk("sc_theta_valid", 64'(sc_theta_valid), 64'(e_scv));
        if (e_scv) chk("sc_theta", sc_theta, e_sct);
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
        if (e_rsp != '0) begin
            chk("rsp_sin", rsp_sin, e_sin);
            chk("rsp_cos", rsp_cos, e_cos);
        end
        chk("err_orphan", 64'(err_orphan), 64'(e_err));
        chk("busy", 64'(busy), 64'(id_q.size() != 0));
        if (err_orphan === 1'b1) err_win++;
        if (rsp_valid != '0) rsp_win++;

        // core reacts to an issue seen this cycle
        if (sc_theta_valid === 1'b1) begin
            slot = (cyc + lat) % RING;
            rs_v[slot] = 1'b1; rs_d[slot] = core_sin(sc_theta);
            slot = (cyc + lat + skew) % RING;
            rc_v[slot] = 1'b1; rc_d[slot] = core_cos(sc_theta);
            if (extra_sin) begin
                extra_sin = 1'b0;
                slot = (cyc + lat + 1) % RING;
                rs_v[slot] = 1'b1; rs_d[slot] = 64'hDEAD_BEEF_0BAD_F00D;
            end
        end
        slot = cyc % RING;
        ss = rs_v[slot]; sv = rs_d[slot]; rs_v[slot] = 1'b0;
        cs = rc_v[slot]; cv = rc_d[slot]; rc_v[slot] = 1'b0;
        sc_sin_valid = ss;
        sc_sin       = ss ? sv : {$urandom, $urandom};
        sc_cos_valid = cs;
        sc_cos       = cs ? cv : {$urandom, $urandom};

        // requesters
        rst = rst_drv;
        for (int i = 0; i < N; i++) begin
            v[i] = use_fix ? vfix[i] : ($urandom_range(99) < vpct);
            req_theta[i*DW +: DW] = {$urandom, $urandom};
        end
        if (budget == 0) v = '0;
        if (fix_th) req_theta[DW-1:0] = th_fix;
        req_valid = v;
        #1;

        // expected grant: first valid from the pointer upward, if credit
        g = -1;
        if (!rst_drv && id_q.size() < MAXO) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && v[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            end
        end
        chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));

        // advance the model across the coming edge
        e_rsp = '0;
        e_err = 1'b0;
        if (rst_drv) begin
            id_q.delete(); sinp.delete(); cosp.delete();
            ptr_m = 0; e_scv = 1'b0; e_sct = '0;
        end else begin
            e_scv = (g >= 0);
            if (g >= 0) begin
                e_sct = req_theta[g*DW +: DW];
                ptr_m = (g + 1) % N;
                if (budget > 0) budget--;
            end
            if ((sinp.size() > 0 || ss) && (cosp.size() > 0 || cs)) begin
                if (sinp.size() > 0) begin ps = sinp.pop_front(); if (ss) sinp.push_back(sv); end
                else ps = sv;
                if (cosp.size() > 0) begin pc = cosp.pop_front(); if (cs) cosp.push_back(cv); end
                else pc = cv;
                if (id_q.size() == 0) e_err = 1'b1;
                else begin
                    e_rsp[id_q.pop_front()] = 1'b1;
                    e_sin = ps; e_cos = pc;
                end
            end else begin
                if (ss) begin if (sinp.size() > 0) e_err = 1'b1; else sinp.push_back(sv); end
                if (cs) begin if (cosp.size() > 0) e_err = 1'b1; else cosp.push_back(cv); end
            end
            if (g >= 0) id_q.push_back(g);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int i = 0; i < RING; i++) begin
            rs_v[i] = 1'b0; rc_v[i] = 1'b0; rs_d[i] = '0; rc_d[i] = '0;
        end
        rst = 1'b1; req_valid = '0; req_theta = '0;
        sc_sin_valid = 1'b0; sc_cos_valid = 1'b0; sc_sin = '0; sc_cos = '0;
        @(negedge clk);

        // T1: reset with all requests asserted
        rst_drv = 1'b1; vpct = 100; run(3);
        rst_drv = 1'b0; vpct = 0;

        // T2: single request from requester 0, latency 20
        lat = 20; skew = 0; use_fix = 1'b1; vfix = 4'b0001;
        fix_th = 1'b1; th_fix = 64'h40091EB851EB851F; budget = 1; rsp_win = 0;
        run(30);
        chk("t2_rsp_count", 64'(rsp_win), 64'd1);
        use_fix = 1'b0; fix_th = 1'b0; budget = -1;

        // T3: all requesters valid, round-robin
        lat = 6; vpct = 100; run(24);
        vpct = 0; run(20);

        // T4: credit limit with long latency
        lat = 40; vpct = 100; run(100);
        vpct = 0; run(50);

        // T5: cos 3 cycles after sin, plus a stray second sin
        lat = 10; skew = 3; use_fix = 1'b1; vfix = 4'b0100; budget = 1;
        fix_th = 1'b0; extra_sin = 1'b1; err_win = 0; rsp_win = 0;
        for (int i = 0; i < N; i++) begin end
        run(25);
        chk("t5_err_count", 64'(err_win), 64'd1);
        chk("t5_rsp_count", 64'(rsp_win), 64'd1);
        use_fix = 1'b0; budget = -1; skew = 0;

        // T6: reset with 5 outstanding, late results become orphans
        lat = 40; vpct = 100; budget = 5; run(8);
        rst_drv = 1'b1; vpct = 0; run(1);
        rst_drv = 1'b0; budget = -1; err_win = 0; rsp_win = 0;
        run(60);
        chk("t6_err_count", 64'(err_win), 64'd5);
        chk("t6_rsp_count", 64'(rsp_win), 64'd0);

        // Randomized phases
        for (int p = 0; p < 6; p++) begin
            lat  = $urandom_range(12, 1);
            skew = $urandom_range(1, 0);
            vpct = $urandom_range(100, 20);
            run(60);
            vpct = 0; run(30);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
